// File: rtl/dram_port_arbiter.sv
// Round-robin, burst-bounded sharing of the single-port image DRAM between the
// processor core (m0) and the image loader (m1); powers the DRAM off once both finish.
module dram_port_arbiter #(
  parameter int AW        = 18,
  parameter int DW        = 9,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_done,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_done,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          dram_write,
  output logic [AW-1:0] dram_addr,
  output logic [DW-1:0] dram_din,
  output logic          dram_off,
  input  logic [DW-1:0] dram_dout
);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2,
    SHUTDOWN = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] beat_cnt_r, beat_cnt_s;
  logic          rr_ptr_r, rr_ptr_s;
  logic          done0_r, done1_r;
  logic          gnt0_r, gnt1_r;
  logic          off_r, off_s;
  logic          rvalid0_r, rvalid1_r;
  logic [DW-1:0] rdata0_r, rdata1_r;
  logic          beat0_s, beat1_s;
  logic          own_is1_s, own_req_s, oth_req_s, own_beat_s;

  assign beat0_s    = gnt0_r & m0_req;
  assign beat1_s    = gnt1_r & m1_req;
  assign own_is1_s  = (state_r == OWN1);
  assign own_req_s  = own_is1_s ? m1_req : m0_req;
  assign oth_req_s  = own_is1_s ? m0_req : m1_req;
  assign own_beat_s = beat0_s | beat1_s;

  // Ownership decision, burst counting and round-robin pointer update
  always_comb begin
    state_s    = state_r;
    beat_cnt_s = beat_cnt_r;
    rr_ptr_s   = rr_ptr_r;
    off_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_s = rr_ptr_r ? OWN1 : OWN0;
        end else if (m0_req) begin
          state_s = OWN0;
        end else if (m1_req) begin
          state_s = OWN1;
        end else if (done0_r && done1_r) begin
          state_s = SHUTDOWN;
          off_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0, OWN1: begin
        // The counter saturates on the last beat so a lone owner keeps the port.
        if (!own_req_s || (own_beat_s && (beat_cnt_r == LAST_BEAT) && oth_req_s)) begin
          state_s    = oth_req_s ? (own_is1_s ? OWN0 : OWN1) : IDLE;
          beat_cnt_s = '0;
          rr_ptr_s   = ~own_is1_s;
        end else if (own_beat_s && (beat_cnt_r != LAST_BEAT)) begin
          beat_cnt_s = beat_cnt_r + CW'(1);
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      SHUTDOWN: begin
        state_s = SHUTDOWN;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state, registered grants, sticky done flags and the off pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      beat_cnt_r <= '0;
      rr_ptr_r   <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      off_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      rr_ptr_r   <= rr_ptr_s;
      done0_r    <= done0_r | m0_done;
      done1_r    <= done1_r | m1_done;
      gnt0_r     <= (state_s == OWN0);
      gnt1_r     <= (state_s == OWN1);
      off_r      <= off_s;
    end
  end

  // Read return: capture DRAM output on each accepted read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
    end else begin
      rvalid0_r <= beat0_s & ~m0_we;
      rvalid1_r <= beat1_s & ~m1_we;
      if (beat0_s && !m0_we) rdata0_r <= dram_dout;
      if (beat1_s && !m1_we) rdata1_r <= dram_dout;
    end
  end

  // DRAM port mux on the current owner
  always_comb begin
    dram_addr  = '0;
    dram_din   = '0;
    dram_write = 1'b0;
    if (gnt0_r) begin
      dram_addr  = m0_addr;
      dram_din   = m0_wdata;
      dram_write = beat0_s & m0_we;
    end else if (gnt1_r) begin
      dram_addr  = m1_addr;
      dram_din   = m1_wdata;
      dram_write = beat1_s & m1_we;
    end else begin
      dram_addr  = '0;
      dram_din   = '0;
      dram_write = 1'b0;
    end
  end

  assign m0_gnt    = gnt0_r;
  assign m1_gnt    = gnt1_r;
  assign m0_rvalid = rvalid0_r;
  assign m1_rvalid = rvalid1_r;
  assign m0_rdata  = rdata0_r;
  assign m1_rdata  = rdata1_r;
  assign dram_off  = off_r;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level ownership/memory model.
module tb_dram_port_arbiter;
  localparam int AW   = 18;
  localparam int DW   = 9;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    req, we, done_in;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          dram_write, dram_off;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_din, dram_dout;

  int total = 0;
  int bad   = 0;

  dram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_done(done_in[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_done(done_in[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dram_write(dram_write), .dram_addr(dram_addr), .dram_din(dram_din),
    .dram_off(dram_off), .dram_dout(dram_dout)
  );

  // DRAM: combinational read, write at the clock edge
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign dram_dout = mem[dram_addr];
  always @(posedge clk) if (dram_write) mem[dram_addr] <= dram_din;
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

  // Reference model: owner (-1 none, 0/1 master, 2 powered off), beats in this tenure
  int            own, run, fav;
  bit  [1:0]     mdone, acc, erv;
  bit            eoff;
  logic [DW-1:0] erd [2];
  logic [DW-1:0] emem [int];

  function automatic logic [DW-1:0] mem_of(int a);
    return emem.exists(a) ? emem[a] : 9'h000;
  endfunction

  task automatic model_reset();
    own = -1; run = 0; fav = 0; mdone = 2'b00; acc = 2'b00; erv = 2'b00; eoff = 1'b0;
    erd[0] = '0; erd[1] = '0;
  endtask

  task automatic model_edge();
    int o;
    if (!rst_n) begin model_reset(); return; end
    acc = 2'b00; erv = 2'b00; eoff = 1'b0;
    if (own == 0 || own == 1) begin
      o = own;
      if (req[o]) begin
        acc[o] = 1'b1;
        run++;
        if (we[o]) emem[int'(addr[o])] = wdata[o];
        else begin erv[o] = 1'b1; erd[o] = mem_of(int'(addr[o])); end
      end
      if (!req[o] || (run >= MAXB && req[1-o])) begin
        fav = 1 - o;
        run = 0;
        own = req[1-o] ? 1 - o : -1;
      end
    end else if (own == -1) begin
      if (req[0] && req[1]) own = fav;
      else if (req[0]) own = 0;
      else if (req[1]) own = 1;
      else if (mdone[0] && mdone[1]) begin own = 2; eoff = 1'b1; end
    end
    if (done_in[0]) mdone[0] = 1'b1;
    if (done_in[1]) mdone[1] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = 2'b00; we = 2'b00; done_in = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 2'b01; we = 2'b01;
    @(negedge clk);
    total++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dram_write, dram_off} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dram_write, dram_off});
    end
    total++; if (dram_addr !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
      bad++; $display("FAIL reset_data: addr %h rdata0 %h rdata1 %h want 0", dram_addr, m0_rdata, m1_rdata);
    end
    apply_reset();
    tick();
    total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL reset_idle: gnt %b%b want 00", m1_gnt, m0_gnt);
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 18'h00010; wdata[0] = 9'h1A5;
    tick();
    total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL wr_gnt: gnt %b%b want 01", m1_gnt, m0_gnt);
    end
    total++; if (dram_write !== 1'b1 || dram_addr !== 18'h00010 || dram_din !== 9'h1A5) begin
      bad++; $display("FAIL wr_port: we %b addr %h din %h want 1 00010 1a5", dram_write, dram_addr, dram_din);
    end
    tick();
    we[0] = 1'b0; #1;
    total++; if (dram_write !== 1'b0) begin
      bad++; $display("FAIL wr_once: dram_write %b want 0", dram_write);
    end
    tick();
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 9'h1A5) begin
      bad++; $display("FAIL raw_read: rvalid %b rdata %h want 1 1a5", m0_rvalid, m0_rdata);
    end
    req[0] = 1'b0;
    tick();
    total++; if (m0_rvalid !== 1'b0 || m0_rdata !== 9'h1A5) begin
      bad++; $display("FAIL rd_hold: rvalid %b rdata %h want 0 1a5", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    int who, want;
    apply_reset();
    req = 2'b11; we = 2'b00; addr[0] = 18'h00100; addr[1] = 18'h00200;
    tick();
    for (int i = 0; i < 12; i++) begin
      who  = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
      want = (i / MAXB) % 2;
      total++; if (who !== want) begin
        bad++; $display("FAIL rr_beat%0d: owner %0d want %0d", i, who, want);
      end
      tick();
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_single_master();
    apply_reset();
    req[1] = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      we[1] = 1'($urandom_range(0, 1)); addr[1] = AW'($urandom_range(0, 63));
      wdata[1] = DW'($urandom_range(0, 511));
      total++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
        bad++; $display("FAIL solo_beat%0d: gnt %b%b want 10", i, m1_gnt, m0_gnt);
      end
      tick();
    end
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_addr_range();
    logic [DW-1:0] v1, v2;
    v1 = DW'($urandom_range(0, 511));
    v2 = ~v1;
    apply_reset();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 18'h3FFFF; wdata[0] = v1;
    tick();
    total++; if (dram_addr !== 18'h3FFFF) begin
      bad++; $display("FAIL top_addr: dram_addr %h want 3ffff", dram_addr);
    end
    tick();
    addr[0] = 18'h00000; wdata[0] = v2;
    tick();
    we[0] = 1'b0; addr[0] = 18'h3FFFF;
    tick();
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== v1) begin
      bad++; $display("FAIL rd_top: rvalid %b rdata %h want 1 %h", m0_rvalid, m0_rdata, v1);
    end
    addr[0] = 18'h00000;
    tick();
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== v2) begin
      bad++; $display("FAIL rd_zero: rvalid %b rdata %h want 1 %h", m0_rvalid, m0_rdata, v2);
    end
    req[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 18'h00020;
    tick();
    tick();
    we[1] = 1'b1; wdata[1] = 9'h0F0; addr[1] = 18'h00021; #1;
    total++; if ({m1_gnt, dram_write, m1_rvalid} !== 3'b111) begin
      bad++; $display("FAIL mid_setup: gnt/we/rvalid %b want 111", {m1_gnt, dram_write, m1_rvalid});
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if ({m1_gnt, dram_write, m1_rvalid} !== 3'b000) begin
      bad++; $display("FAIL async_drop: gnt/we/rvalid %b want 000", {m1_gnt, dram_write, m1_rvalid});
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1; req = 2'b11; we = 2'b00;
    tick();
    total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL post_reset_fav: gnt %b%b want 01", m1_gnt, m0_gnt);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_shutdown();
    int offs, at;
    apply_reset();
    done_in[0] = 1'b1;
    tick();
    done_in[0] = 1'b0; done_in[1] = 1'b1;
    offs = 0; at = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_in[1] = 1'b0;
      if (dram_off) begin offs++; if (at < 0) at = i; end
    end
    total++; if (offs !== 1 || at !== 1) begin
      bad++; $display("FAIL off_pulse: cycles %0d at %0d want 1 at 1", offs, at);
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
        bad++; $display("FAIL off_nogrant%0d: gnt %b%b want 00", i, m1_gnt, m0_gnt);
      end
    end
    apply_reset();
    req[0] = 1'b1; we[0] = 1'b0; done_in = 2'b11;
    tick();
    done_in = 2'b00;
    for (int i = 0; i < 3; i++) begin
      total++; if (dram_off !== 1'b0 || m0_gnt !== 1'b1) begin
        bad++; $display("FAIL off_pending%0d: off %b gnt0 %b want 0 1", i, dram_off, m0_gnt);
      end
      tick();
    end
    req[0] = 1'b0;
    tick();
    total++; if (dram_off !== 1'b0) begin
      bad++; $display("FAIL off_early: off %b want 0", dram_off);
    end
    tick();
    total++; if (dram_off !== 1'b1) begin
      bad++; $display("FAIL off_late: off %b want 1", dram_off);
    end
    tick();
    total++; if (dram_off !== 1'b0) begin
      bad++; $display("FAIL off_width: off %b want 0", dram_off);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_din;
    logic          ex_wr;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] || acc[m]) begin
          req[m]   = ($urandom_range(0, 9) < 6);
          we[m]    = 1'($urandom_range(0, 1));
          addr[m]  = AW'($urandom_range(0, 15));
          wdata[m] = DW'($urandom_range(0, 511));
        end
        done_in[m] = ($urandom_range(0, 99) == 0);
      end
      #1;
      ex_addr = '0; ex_din = '0; ex_wr = 1'b0;
      if (own == 0 || own == 1) begin
        ex_addr = addr[own]; ex_din = wdata[own]; ex_wr = req[own] & we[own];
      end
      total++; if (m0_gnt !== (own == 0) || m1_gnt !== (own == 1)) begin
        bad++; $display("FAIL rnd_gnt c%0d: gnt %b%b model owner %0d", c, m1_gnt, m0_gnt, own);
      end
      total++; if ({m1_rvalid, m0_rvalid} !== erv) begin
        bad++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, {m1_rvalid, m0_rvalid}, erv);
      end
      total++; if (m0_rdata !== erd[0] || m1_rdata !== erd[1]) begin
        bad++; $display("FAIL rnd_rdata c%0d: got %h %h want %h %h", c, m0_rdata, m1_rdata, erd[0], erd[1]);
      end
      total++; if (dram_write !== ex_wr || dram_addr !== ex_addr || dram_din !== ex_din) begin
        bad++; $display("FAIL rnd_port c%0d: got %b %h %h want %b %h %h", c, dram_write, dram_addr, dram_din, ex_wr, ex_addr, ex_din);
      end
      total++; if (dram_off !== eoff) begin
        bad++; $display("FAIL rnd_off c%0d: got %b want %b", c, dram_off, eoff);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; req = 2'b00; we = 2'b00; done_in = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    model_reset();
    #2 rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_single_master();
    test_addr_range();
    test_reset_mid_burst();
    test_shutdown();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
